// File: rtl/timer_pkg.sv
// Shared constants for the countdown timer device: register map, CTRL field
// positions, mode encodings and FSM state encoding.
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_dev.sv
// Programmable countdown timer with CTRL/PRESET/COUNT registers and a maskable
// interrupt request for one HWInt line.
module timer_dev
  import timer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              Wen,
  input  logic [WIDTH-1:0]  DIn,
  output logic [WIDTH-1:0]  DOut,
  output logic              IRQ
);

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             irq_flag_q, irq_flag_d;

  logic en;
  logic reload;
  logic ctrlWr;
  logic presetWr;

  assign en       = ctrl_q[CTRL_EN];
  assign reload   = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  assign ctrlWr   = Wen && (Addr == ADDR_CTRL);
  assign presetWr = Wen && (Addr == ADDR_PRESET);

  // Software writes clear the flag first so an FSM set in the same cycle wins,
  // while software CTRL writes are applied last so they override the En auto-clear.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    if (ctrlWr || presetWr) begin
      irq_flag_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q <= WIDTH'(1)) begin
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      ST_INT: begin
        if (reload) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ctrlWr) begin
      ctrl_d = DIn[3:0];
    end
    if (presetWr) begin
      preset_d = DIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= {1'b0, MODE_ONESHOT, 1'b0};
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    case (Addr)
      ADDR_CTRL:   DOut = {{(WIDTH-4){1'b0}}, ctrl_q};
      ADDR_PRESET: DOut = preset_q;
      ADDR_COUNT:  DOut = count_q;
      default:     DOut = '0;
    endcase
  end

  assign IRQ = irq_flag_q & ctrl_q[CTRL_IM];

endmodule
